// File: rtl/lut_prog_pkg.sv
// Shared types and default sizing for the programmable neuron LUT.
// LUT_READBACK_EN adds the RDBK state used for table readback.
package lut_prog_pkg;

    localparam int LUT_IN_BITS  = 8;
    localparam int LUT_OUT_BITS = 2;
    localparam int LUT_DEPTH    = 1 << LUT_IN_BITS;

`ifdef LUT_READBACK_EN
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2,
        ST_RDBK  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2
    } state_t;
`endif

endpackage

// File: rtl/layer_lut_prog_if.sv
// Load, lookup and (with LUT_READBACK_EN) readback signals of layer_lut_prog.
// master = host / fan-in side, slave = the LUT block.
interface layer_lut_prog_if #(
    parameter int IN_BITS  = lut_prog_pkg::LUT_IN_BITS,
    parameter int OUT_BITS = lut_prog_pkg::LUT_OUT_BITS
) ();
    logic                cfg_start;
    logic                cfg_valid;
    logic                cfg_ready;
    logic [OUT_BITS-1:0] cfg_data;
    logic                cfg_done;
    logic                loaded;
    logic                in_valid;
    logic [IN_BITS-1:0]  in_data;
    logic                out_valid;
    logic [OUT_BITS-1:0] out_data;
`ifdef LUT_READBACK_EN
    logic                rb_req;
    logic                rb_valid;
    logic [OUT_BITS-1:0] rb_data;
    logic                rb_last;
`endif

    modport master (
        output cfg_start, cfg_valid, cfg_data, in_valid, in_data,
`ifdef LUT_READBACK_EN
        output rb_req,
        input  rb_valid, rb_data, rb_last,
`endif
        input  cfg_ready, cfg_done, loaded, out_valid, out_data
    );

    modport slave (
        input  cfg_start, cfg_valid, cfg_data, in_valid, in_data,
`ifdef LUT_READBACK_EN
        input  rb_req,
        output rb_valid, rb_data, rb_last,
`endif
        output cfg_ready, cfg_done, loaded, out_valid, out_data
    );
endinterface

// File: rtl/lut_prog_ram.sv
// Distributed table storage: one synchronous write port, asynchronous reads.
// A second read port for readback exists when LUT_READBACK_EN is defined.
// Storage is intentionally not reset.
module lut_prog_ram
    import lut_prog_pkg::*;
#(
    parameter int IN_BITS  = LUT_IN_BITS,
    parameter int OUT_BITS = LUT_OUT_BITS
) (
    input  logic                clk,
    input  logic                we,
    input  logic [IN_BITS-1:0]  waddr,
    input  logic [OUT_BITS-1:0] wdata,
    input  logic [IN_BITS-1:0]  raddr_a,
    output logic [OUT_BITS-1:0] rdata_a
`ifdef LUT_READBACK_EN
    ,
    input  logic [IN_BITS-1:0]  raddr_b,
    output logic [OUT_BITS-1:0] rdata_b
`endif
);
    localparam int DEPTH = 1 << IN_BITS;

    (* ram_style = "distributed", rom_style = "distributed" *)
    logic [OUT_BITS-1:0] mem [DEPTH];

    // write port
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata_a = mem[raddr_a];
`ifdef LUT_READBACK_EN
    assign rdata_b = mem[raddr_b];
`endif

endmodule

// File: rtl/layer_lut_prog.sv
// Run-time programmable LogicNets neuron truth table.
// Host streams 2^IN_BITS entries in ascending address order, then the block
// serves one-cycle registered lookups. LUT_READBACK_EN adds table readback.
module layer_lut_prog
    import lut_prog_pkg::*;
#(
    parameter int IN_BITS  = LUT_IN_BITS,
    parameter int OUT_BITS = LUT_OUT_BITS
) (
    input  logic            clk,
    input  logic            rst_n,
    layer_lut_prog_if.slave bus
);
    localparam logic [IN_BITS-1:0] ADDR_LAST = '1;

    state_t              state, state_nxt;
    logic [IN_BITS-1:0]  addr, addr_nxt;
    logic                wr_en;
    logic                done_nxt;
    logic                cfg_done_q;
    logic                loaded_w;
    logic [OUT_BITS-1:0] lut_rd;
    logic                out_valid_q;
    logic [OUT_BITS-1:0] out_data_q;
`ifdef LUT_READBACK_EN
    logic [IN_BITS-1:0]  rb_cnt, rb_cnt_nxt;
    logic [OUT_BITS-1:0] rb_rd;
`endif

    lut_prog_ram #(
        .IN_BITS  (IN_BITS),
        .OUT_BITS (OUT_BITS)
    ) u_ram (
        .clk     (clk),
        .we      (wr_en),
        .waddr   (addr),
        .wdata   (bus.cfg_data),
        .raddr_a (bus.in_data),
        .rdata_a (lut_rd)
`ifdef LUT_READBACK_EN
        ,
        .raddr_b (rb_cnt),
        .rdata_b (rb_rd)
`endif
    );

    // control state, load address, done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_EMPTY;
            addr       <= '0;
            cfg_done_q <= 1'b0;
`ifdef LUT_READBACK_EN
            rb_cnt     <= '0;
`endif
        end else begin
            state      <= state_nxt;
            addr       <= addr_nxt;
            cfg_done_q <= done_nxt;
`ifdef LUT_READBACK_EN
            rb_cnt     <= rb_cnt_nxt;
`endif
        end
    end

    // next state, table write and counter updates; cfg_start always wins
    always_comb begin
        state_nxt  = state;
        addr_nxt   = addr;
        wr_en      = 1'b0;
        done_nxt   = 1'b0;
`ifdef LUT_READBACK_EN
        rb_cnt_nxt = rb_cnt;
`endif
        case (state)
            ST_EMPTY: begin
                if (bus.cfg_start) begin
                    state_nxt = ST_LOAD;
                    addr_nxt  = '0;
                end
            end
            ST_LOAD: begin
                if (bus.cfg_start) begin
                    addr_nxt = '0;
                end else if (bus.cfg_valid) begin
                    wr_en    = 1'b1;
                    addr_nxt = addr + IN_BITS'(1);
                    if (addr == ADDR_LAST) begin
                        state_nxt = ST_READY;
                        done_nxt  = 1'b1;
                    end
                end
            end
            ST_READY: begin
                if (bus.cfg_start) begin
                    state_nxt = ST_LOAD;
                    addr_nxt  = '0;
                end
`ifdef LUT_READBACK_EN
                else if (bus.rb_req) begin
                    state_nxt  = ST_RDBK;
                    rb_cnt_nxt = '0;
                end
`endif
            end
`ifdef LUT_READBACK_EN
            ST_RDBK: begin
                if (bus.cfg_start) begin
                    state_nxt = ST_LOAD;
                    addr_nxt  = '0;
                end else begin
                    rb_cnt_nxt = rb_cnt + IN_BITS'(1);
                    if (rb_cnt == ADDR_LAST) state_nxt = ST_READY;
                end
            end
`endif
            default: begin
                state_nxt = ST_EMPTY;
                addr_nxt  = '0;
            end
        endcase
    end

`ifdef LUT_READBACK_EN
    assign loaded_w = (state == ST_READY) || (state == ST_RDBK);
`else
    assign loaded_w = (state == ST_READY);
`endif

    // registered lookup; a stale or partial table is never exposed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= bus.in_valid;
            out_data_q  <= (bus.in_valid && loaded_w) ? lut_rd : '0;
        end
    end

    assign bus.cfg_ready = (state == ST_LOAD);
    assign bus.cfg_done  = cfg_done_q;
    assign bus.loaded    = loaded_w;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
`ifdef LUT_READBACK_EN
    assign bus.rb_valid  = (state == ST_RDBK);
    assign bus.rb_data   = (state == ST_RDBK) ? rb_rd : '0;
    assign bus.rb_last   = (state == ST_RDBK) && (rb_cnt == ADDR_LAST);
`endif

endmodule

// File: tb/tb_layer_lut_prog.sv
// Self-checking bench for layer_lut_prog (readback section under LUT_READBACK_EN).
module tb_layer_lut_prog;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    layer_lut_prog_if #(.IN_BITS(8), .OUT_BITS(2)) bus ();

    layer_lut_prog #(.IN_BITS(8), .OUT_BITS(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors    = 0;
    int miscompares = 0;

    // reference: the table image the host last completed, and whether it is live
    logic [1:0] exp_tab [256];
    logic [1:0] new_tab [256];
    bit         exp_loaded;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.cfg_start = 0; bus.cfg_valid = 0; bus.cfg_data = 0;
        bus.in_valid = 0;  bus.in_data = 0;
`ifdef LUT_READBACK_EN
        bus.rb_req = 0;
`endif
        for (int i = 0; i < 256; i++) exp_tab[i] = 2'b00;
        exp_loaded = 0;
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({bus.cfg_ready, bus.cfg_done, bus.loaded, bus.out_valid, bus.out_data} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got rdy=%b done=%b ld=%b ov=%b od=%b want all 0",
                     bus.cfg_ready, bus.cfg_done, bus.loaded, bus.out_valid, bus.out_data);
        end
`ifdef LUT_READBACK_EN
        vectors++;
        if ({bus.rb_valid, bus.rb_last, bus.rb_data} !== 4'b0) begin
            miscompares++;
            $display("FAIL reset_rb: got v=%b l=%b d=%b want 0", bus.rb_valid, bus.rb_last, bus.rb_data);
        end
`endif
        rst_n = 1;
        step();
        bus.in_valid = 1; bus.in_data = 8'h00;
        step();
        bus.in_valid = 0;
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 2'b00 || bus.loaded !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_lookup: got ov=%b od=%b ld=%b want ov=1 od=0 ld=0",
                     bus.out_valid, bus.out_data, bus.loaded);
        end
    endtask

    // Streams new_tab into the DUT. probe: 0 none, 1 lookup 8'h07 on the final
    // beat, 2 random lookup on every beat. Lookups during a load must return 0.
    task automatic load_table(input bit do_start, input bit toggle, input int probe, input string tag);
        int  hs, cyc;
        bit  early, notready, lk;
        logic [7:0] la;
        if (do_start) begin
            bus.cfg_start = 1;
            step();
            bus.cfg_start = 0;
        end
        exp_loaded = 0;
        vectors++;
        if (bus.cfg_ready !== 1'b1 || bus.loaded !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_enter_load: got rdy=%b ld=%b want rdy=1 ld=0", tag, bus.cfg_ready, bus.loaded);
        end
        hs = 0; cyc = 0; early = 0; notready = 0;
        while (hs < 256 && cyc < 2000) begin
            bus.cfg_valid = toggle ? (cyc % 2 == 0) : 1'b1;
            bus.cfg_data  = new_tab[hs];
            lk = (probe == 2) || (probe == 1 && hs == 255 && bus.cfg_valid);
            la = (probe == 2) ? 8'($urandom) : 8'h07;
            bus.in_valid = lk;
            bus.in_data  = la;
            if (bus.cfg_valid && bus.cfg_ready !== 1'b1) notready = 1;
            step();
            cyc++;
            if (bus.cfg_valid) hs++;
            if (hs < 256 && bus.cfg_done !== 1'b0) early = 1;
            if (lk) begin
                vectors++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== 2'b00) begin
                    miscompares++;
                    $display("FAIL %s_lookup_in_load: addr=%h got ov=%b od=%b want ov=1 od=0",
                             tag, la, bus.out_valid, bus.out_data);
                end
            end
        end
        bus.cfg_valid = 0;
        bus.in_valid  = 0;
        vectors++;
        if (early || notready || hs != 256) begin
            miscompares++;
            $display("FAIL %s_handshakes: got early_done=%b not_ready=%b hs=%0d want 0 0 256",
                     tag, early, notready, hs);
        end
        vectors++;
        if (cyc != (toggle ? 511 : 256)) begin
            miscompares++;
            $display("FAIL %s_load_cycles: got %0d want %0d", tag, cyc, toggle ? 511 : 256);
        end
        vectors++;
        if (bus.cfg_done !== 1'b1 || bus.loaded !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_done: got done=%b ld=%b want 1 1", tag, bus.cfg_done, bus.loaded);
        end
        for (int i = 0; i < 256; i++) exp_tab[i] = new_tab[i];
        exp_loaded = 1;
        step();
        vectors++;
        if (bus.cfg_done !== 1'b0 || bus.loaded !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_done_pulse: got done=%b ld=%b want 0 1", tag, bus.cfg_done, bus.loaded);
        end
    endtask

    task automatic test_random_lookups(input int n, input string tag);
        bit v;
        logic [7:0] a;
        logic [1:0] want;
        for (int k = 0; k < n; k++) begin
            v = ($urandom_range(0, 3) != 0);
            a = 8'($urandom);
            bus.in_valid = v;
            bus.in_data  = a;
            step();
            vectors++;
            if (bus.out_valid !== v) begin
                miscompares++;
                $display("FAIL %s_out_valid: got %b want %b", tag, bus.out_valid, v);
            end
            if (v) begin
                want = exp_loaded ? exp_tab[a] : 2'b00;
                vectors++;
                if (bus.out_data !== want) begin
                    miscompares++;
                    $display("FAIL %s_out_data: addr=%h got %b want %b", tag, a, bus.out_data, want);
                end
            end
        end
        bus.in_valid = 0;
    endtask

    task automatic test_load_basic();
        logic [7:0] addrs [2];
        logic [1:0] wants [2];
        for (int i = 0; i < 256; i++) new_tab[i] = 2'(i);
        load_table(1, 0, 1, "basic");
        addrs[0] = 8'h07; wants[0] = 2'b11;
        addrs[1] = 8'hF4; wants[1] = 2'b00;
        for (int k = 0; k < 2; k++) begin
            bus.in_valid = 1; bus.in_data = addrs[k];
            step();
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== wants[k]) begin
                miscompares++;
                $display("FAIL basic_lookup_%h: got ov=%b od=%b want ov=1 od=%b",
                         addrs[k], bus.out_valid, bus.out_data, wants[k]);
            end
        end
        bus.in_valid = 0;
        test_random_lookups(60, "basic_rand");
    endtask

    task automatic test_toggle_load();
        for (int i = 0; i < 256; i++) new_tab[i] = 2'($urandom);
        load_table(1, 1, 0, "toggle");
        test_random_lookups(200, "toggle_rand");
    endtask

    task automatic test_restart();
        bus.cfg_start = 1;
        step();
        bus.cfg_start = 0;
        for (int i = 0; i < 100; i++) begin
            bus.cfg_valid = 1; bus.cfg_data = 2'($urandom);
            step();
        end
        bus.cfg_start = 1; bus.cfg_valid = 1; bus.cfg_data = 2'($urandom);
        step();
        bus.cfg_start = 0; bus.cfg_valid = 0;
        vectors++;
        if (bus.cfg_done !== 1'b0 || bus.cfg_ready !== 1'b1 || bus.loaded !== 1'b0) begin
            miscompares++;
            $display("FAIL restart_state: got done=%b rdy=%b ld=%b want 0 1 0",
                     bus.cfg_done, bus.cfg_ready, bus.loaded);
        end
        for (int i = 0; i < 256; i++) new_tab[i] = 2'($urandom);
        load_table(0, 0, 0, "restart");
        test_random_lookups(200, "restart_rand");
    endtask

    task automatic test_reload_ready();
        for (int i = 0; i < 256; i++) new_tab[i] = 2'b10;
        load_table(1, 0, 2, "reload");
        test_random_lookups(40, "reload_rand");
    endtask

    task automatic test_reset_midload();
        bus.cfg_start = 1;
        step();
        bus.cfg_start = 0;
        for (int i = 0; i < 40; i++) begin
            bus.cfg_valid = 1; bus.cfg_data = 2'($urandom);
            step();
        end
        rst_n = 0;
        #2;
        exp_loaded = 0;
        vectors++;
        if (bus.cfg_ready !== 1'b0 || bus.loaded !== 1'b0 || bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midload_reset: got rdy=%b ld=%b ov=%b want 0 0 0",
                     bus.cfg_ready, bus.loaded, bus.out_valid);
        end
        step();
        rst_n = 1;
        for (int i = 0; i < 20; i++) step();
        bus.cfg_valid = 0;
        vectors++;
        if (bus.cfg_ready !== 1'b0 || bus.cfg_done !== 1'b0 || bus.loaded !== 1'b0) begin
            miscompares++;
            $display("FAIL empty_ignores_valid: got rdy=%b done=%b ld=%b want 0 0 0",
                     bus.cfg_ready, bus.cfg_done, bus.loaded);
        end
        test_random_lookups(20, "empty_rand");
        for (int i = 0; i < 256; i++) new_tab[i] = 2'($urandom);
        load_table(1, 0, 0, "after_reset");
        test_random_lookups(100, "after_reset_rand");
    endtask

`ifdef LUT_READBACK_EN
    task automatic test_readback();
        bit v;
        logic [7:0] a;
        logic [1:0] want;
        for (int i = 0; i < 256; i++) new_tab[i] = 2'(i);
        load_table(1, 0, 0, "rb_load");
        bus.rb_req = 1;
        step();
        bus.rb_req = 0;
        for (int k = 0; k < 256; k++) begin
            vectors++;
            if (bus.rb_valid !== 1'b1 || bus.rb_data !== exp_tab[k] || bus.rb_last !== (k == 255)) begin
                miscompares++;
                $display("FAIL rb_entry_%0d: got v=%b d=%b l=%b want v=1 d=%b l=%b",
                         k, bus.rb_valid, bus.rb_data, bus.rb_last, exp_tab[k], k == 255);
            end
            v = 1'b1; a = 8'($urandom);
            bus.in_valid = v; bus.in_data = a;
            bus.rb_req = (k == 100);
            step();
            want = exp_tab[a];
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== want) begin
                miscompares++;
                $display("FAIL rb_lookup: addr=%h got ov=%b od=%b want 1 %b", a, bus.out_valid, bus.out_data, want);
            end
        end
        bus.in_valid = 0; bus.rb_req = 0;
        vectors++;
        if (bus.rb_valid !== 1'b0 || bus.loaded !== 1'b1) begin
            miscompares++;
            $display("FAIL rb_end: got v=%b ld=%b want 0 1", bus.rb_valid, bus.loaded);
        end
        bus.rb_req = 1;
        step();
        bus.rb_req = 0;
        for (int k = 0; k <= 50; k++) begin
            vectors++;
            if (bus.rb_valid !== 1'b1 || bus.rb_data !== exp_tab[k]) begin
                miscompares++;
                $display("FAIL rb2_entry_%0d: got v=%b d=%b want 1 %b", k, bus.rb_valid, bus.rb_data, exp_tab[k]);
            end
            bus.cfg_start = (k == 50);
            step();
        end
        bus.cfg_start = 0;
        exp_loaded = 0;
        vectors++;
        if (bus.rb_valid !== 1'b0 || bus.loaded !== 1'b0 || bus.cfg_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rb_abort: got v=%b ld=%b rdy=%b want 0 0 1", bus.rb_valid, bus.loaded, bus.cfg_ready);
        end
        for (int i = 0; i < 256; i++) new_tab[i] = 2'($urandom);
        load_table(0, 0, 0, "rb_reload");
        test_random_lookups(50, "rb_reload_rand");
    endtask
`endif

    initial begin
        test_reset();
        test_load_basic();
        test_toggle_load();
        test_restart();
        test_reload_ready();
        test_reset_midload();
`ifdef LUT_READBACK_EN
        test_readback();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
